// File: rtl/slot_demux_pkg.sv
// Shared types and default sizing for the slot demultiplexer.
//   state_e   : snapshot controller states
//   DEF_WIDTH : default bit width of one slot value
//   DEF_SLOTS : default slot count per frame
package slot_demux_pkg;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned DEF_SLOTS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAPT = 2'd2
    } state_e;

endpackage

// File: rtl/slot_demux_if.sv
// Slot bus and snapshot handshake bundle for slot_demux.
//   cen, mixed, cnt     : clock enable, multiplexed slot value, global slot counter
//   snap_req/busy/ack   : snapshot request, pending/capturing flag, completion pulse
//   rd_slot, rd_data    : snapshot read address and registered read data
//   frame_valid         : every slot written since reset
//   chg_mask            : per-slot changed-since-last-snapshot flags
// master drives the inputs of the block, slave is the block itself.
interface slot_demux_if
    import slot_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLOTS = DEF_SLOTS
);
    localparam int unsigned CW = $clog2(SLOTS);

    logic             cen;
    logic [WIDTH-1:0] mixed;
    logic [CW-1:0]    cnt;
    logic             snap_req;
    logic             snap_busy;
    logic             snap_ack;
    logic [CW-1:0]    rd_slot;
    logic [WIDTH-1:0] rd_data;
    logic             frame_valid;
    logic [SLOTS-1:0] chg_mask;

    modport master (
        output cen, mixed, cnt, snap_req, rd_slot,
        input  snap_busy, snap_ack, rd_data, frame_valid, chg_mask
    );

    modport slave (
        input  cen, mixed, cnt, snap_req, rd_slot,
        output snap_busy, snap_ack, rd_data, frame_valid, chg_mask
    );

endinterface

// File: rtl/slot_demux_ram.sv
// Snapshot storage: DEPTH x WIDTH, one write port, one registered read port.
//   clk, rst : clock, synchronous active-high reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : read address, read data one clk later
module slot_demux_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register runs every clk, regardless of the slot clock enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slot_demux.sv
// Demultiplexes a time-multiplexed slot stream into per-slot registers and
// captures whole-frame snapshots on request.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slot_demux_if.slave (slot stream in, snapshot handshake/read out)
// Parameters: WIDTH slot width, SLOTS slots per frame (power of two),
//   STG pipeline stage of the sampled signal.
// Optional feature: define SLOT_DEMUX_CHG_EN to build per-slot change flags;
//   otherwise chg_mask is tied to zero.
module slot_demux
    import slot_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLOTS = DEF_SLOTS,
    parameter int unsigned STG   = 0
) (
    input  logic         clk,
    input  logic         rst,
    slot_demux_if.slave  bus
);

    localparam int unsigned CW      = $clog2(SLOTS);
    localparam int unsigned ADJ_OFS = (SLOTS + 1 - STG) % SLOTS;

    logic [CW-1:0]    adj_c;
    logic [WIDTH-1:0] live_q [SLOTS];
    logic [SLOTS-1:0] written_q;
    logic             frame_valid_q;
    state_e           state_q;
    logic             busy_q;
    logic             ack_q;
    logic             snap_we_c;
    logic [WIDTH-1:0] rd_data_w;

    // Slot the current sample belongs to; CW-bit truncation gives the wrap.
    assign adj_c = bus.cnt + CW'(ADJ_OFS);

    always_ff @(posedge clk) begin
        if (bus.cen) begin
            live_q[adj_c] <= bus.mixed;
        end
    end

    // frame_valid trails the last written bit by one clk and is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            written_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            if (bus.cen) begin
                written_q[adj_c] <= 1'b1;
            end
            if (&written_q) begin
                frame_valid_q <= 1'b1;
            end
        end
    end

    // Snapshot controller: arm on request, capture one full frame starting at slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (bus.cen) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.snap_req) begin
                            state_q <= ST_ARM;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        if (adj_c == '0) begin
                            state_q <= ST_CAPT;
                        end
                    end
                    ST_CAPT: begin
                        if (adj_c == CW'(SLOTS - 1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            ack_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The ARM->CAPT cycle already holds slot 0, so it writes too.
    assign snap_we_c = bus.cen &&
                       (((state_q == ST_ARM) && (adj_c == '0)) || (state_q == ST_CAPT));

    slot_demux_ram #(
        .WIDTH (WIDTH),
        .DEPTH (SLOTS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (snap_we_c),
        .waddr_i (adj_c),
        .wdata_i (bus.mixed),
        .raddr_i (bus.rd_slot),
        .rdata_o (rd_data_w)
    );

`ifdef SLOT_DEMUX_CHG_EN
    logic [SLOTS-1:0] chg_q;
    logic [SLOTS-1:0] chg_set_c;

    // A slot with no prior write has nothing to compare against, so it never flags.
    always_comb begin
        chg_set_c = '0;
        if (bus.cen && written_q[adj_c] && (live_q[adj_c] != bus.mixed)) begin
            chg_set_c[adj_c] = 1'b1;
        end
    end

    // Clear on the ack cycle; a change landing in that same cycle survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= '0;
        end else if (ack_q) begin
            chg_q <= chg_set_c;
        end else begin
            chg_q <= chg_q | chg_set_c;
        end
    end

    assign bus.chg_mask = chg_q;
`else
    logic [WIDTH-1:0] live_fold_unused;

    // Live array only feeds change detection; sink it here so it is not dead storage.
    always_comb begin
        live_fold_unused = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            live_fold_unused = live_fold_unused ^ live_q[CW'(i)];
        end
    end

    assign bus.chg_mask = '0;
`endif

    assign bus.snap_busy   = busy_q;
    assign bus.snap_ack    = ack_q;
    assign bus.rd_data     = rd_data_w;
    assign bus.frame_valid = frame_valid_q;

endmodule

// File: doc/slot_demux.md
SLOT_DEMUX -- requirements
Module: slot_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bit width of each slot value.
REQ-002 SHALL have parameter SLOTS, default 32, slot count per frame, power of two in 8..64; CW = log2(SLOTS).
REQ-003 SHALL have parameter STG, default 0, pipeline stage of the sampled signal (0..SLOTS-1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cen  input  1  clock enable; all state frozen when low.
REQ-007 SHALL have port mixed  input  WIDTH  time-multiplexed slot value.
REQ-008 SHALL have port cnt  input  CW  global slot counter.
REQ-009 SHALL have port snap_req  input  1  single-cycle snapshot request.
REQ-010 SHALL have port snap_busy  output  1  snapshot pending or capturing.
REQ-011 SHALL have port snap_ack  output  1  one-cycle pulse when snapshot complete.
REQ-012 SHALL have port rd_slot  input  CW  snapshot read address.
REQ-013 SHALL have port rd_data  output  WIDTH  snapshot value of rd_slot.
REQ-014 SHALL have port frame_valid  output  1  every slot written since reset.
REQ-015 SHALL have port chg_mask  output  SLOTS  per-slot changed-since-last-snapshot flags.

Function
REQ-016 SHALL compute slot index adj = (cnt + SLOTS + 1 - STG) mod SLOTS, combinationally, CW bits, wrap-around natural.
REQ-017 SHALL, on each cen cycle, write mixed into live[adj] and set written[adj].
REQ-018 SHALL assert frame_valid the cycle after the last written bit is set; it remains high until reset.
REQ-019 SHALL implement FSM IDLE -> ARM -> CAPT -> IDLE; snap_busy high in ARM and CAPT.
REQ-020 SHALL move IDLE -> ARM on snap_req high with cen high; snap_req in ARM/CAPT ignored, not queued.
REQ-021 SHALL move ARM -> CAPT on the first cen cycle after the request with adj == 0; that cycle's mixed is captured as slot 0.
REQ-022 SHALL, in CAPT, write mixed into snap[adj] each cen cycle; after adj == SLOTS-1 is captured, move to IDLE and pulse snap_ack for exactly one clk cycle.
REQ-023 SHALL, with cen low, hold FSM, snapshot, live and written state; snap_ack never extends beyond one clk.
REQ-024 SHALL register rd_data = snap[rd_slot] with one clk latency, independent of cen; reads during CAPT may return mixed old/new data.
REQ-025 SHALL, when snap_req and adj == 0 coincide, enter ARM only; capture starts at the next frame.

Reset
REQ-026 SHALL on rst clear FSM to IDLE, snap_busy, snap_ack, frame_valid, written, chg_mask, rd_data to 0.
REQ-027 SHALL leave live and snap arrays uninitialised; reset mid-capture aborts with no snap_ack.

Configuration
REQ-028 SHALL honour macro SLOT_DEMUX_CHG_EN: when defined, chg_mask[i] sets on a cen write to live[i] whose value differs from the stored value, and all bits clear on the snap_ack cycle (a same-cycle set wins).
REQ-029 SHALL, without SLOT_DEMUX_CHG_EN, drive chg_mask constant 0 and synthesise no compare logic.

Structure
REQ-030 SHALL place the FSM state enum and default WIDTH/SLOTS constants in package slot_demux_pkg.
REQ-031 SHALL use one sub-module slot_demux_ram (1 write port, 1 registered read port, SLOTS x WIDTH) for the snapshot array; live array stays flat registers.

Verification
REQ-032 SHALL verify: STG=0, cnt ramps 0..31, mixed = cnt*3 -> live[(cnt+1)%32] == cnt*3; frame_valid rises 1 clk after 32nd write.
REQ-033 SHALL verify: snap_req at cnt=5, STG=0 -> capture starts at cnt=31 (adj 0), snap_ack 32 cen cycles later; rd_slot=7 returns value sampled at cnt=6.
REQ-034 SHALL verify: second snap_req during CAPT -> ignored, exactly one snap_ack.
REQ-035 SHALL verify: cen low for 10 cycles mid-CAPT -> capture resumes, snapshot identical to no-stall run.
REQ-036 SHALL verify: rst at CAPT slot 12 -> snap_busy 0 next cycle, no snap_ack, frame_valid 0.
REQ-037 SHALL verify with SLOT_DEMUX_CHG_EN: slot 3 changes 0x055 -> 0x0AA -> chg_mask = 0x8; cleared on snap_ack.
